// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry shared across the CPU core.
//   REG_ADDR_W / REG_DATA_W : default address and data widths
//   REG_ZERO                : the hard-wired zero register
//   reg_addr_t              : register address type
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and flush signals of the multi-port register file.
//   master : pipeline side (drives addresses, write data, issue and flush)
//   slave  : register file side (returns bypassed read data and busy bits)
interface regfile_mp_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_vld;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_vld, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_vld, iss_addr, flush,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for D-stage stall detection.
//   clk, reset      : clock, asynchronous active-low reset
//   iss_vld/addr    : issued destination, sets busy
//   wr_en/addr      : writebacks, clear busy
//   flush           : clears every busy bit (dominates issue)
//   rd_addr/rd_busy : busy lookup per read port, masked by same-cycle writeback
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Clears applied first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != '0)
          busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_vld && iss_addr != '0)
        busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A register being written back this cycle is already available via bypass.
  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic              clr;
      a   = rd_addr[i*ADDR_W +: ADDR_W];
      clr = 1'b0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == a)
          clr = 1'b1;
      end
      rd_busy[i] = (a != '0) && busy_q[a] && !clr;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general register file with write-to-read bypass and busy scoreboard.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears registers and busy bits, blanks reads)
//   bus   : regfile_mp_if.slave (read/write/issue/flush signals)
// Register 0 reads as zero and is never busy; higher write port index wins on collision.
// Define REGFILE_TRACE_EN to print every committed write in simulation.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;

  // Ascending port order makes the highest-index writer win.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (bus.wr_en[k] && bus.wr_addr[k*ADDR_W +: ADDR_W] != '0)
        regs_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = bus.wr_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] word;
      a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      word = regs_q[a];
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && bus.wr_addr[k*ADDR_W +: ADDR_W] == a)
          word = bus.wr_data[k*DATA_W +: DATA_W];
      end
      if (a == '0 || !reset) word = '0;
      rd_data_c[i*DATA_W +: DATA_W] = word;
    end
  end

  assign bus.rd_data = rd_data_c;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_vld  (bus.iss_vld),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && bus.wr_addr[k*ADDR_W +: ADDR_W] != '0)
          $display("%0t: $%0d <= %h", $time, bus.wr_addr[k*ADDR_W +: ADDR_W],
                   bus.wr_data[k*DATA_W +: DATA_W]);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk;
  logic reset;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld;
  int   checks;
  int   failures;

  // Monitor: compares the DUT's combinational outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL no_expectation: output sampled with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data[31:0] !== e.d0) begin
          failures++;
          $display("FAIL %s rd_data0: got %h want %h", e.nm, bus.rd_data[31:0], e.d0);
        end
        checks++;
        if (bus.rd_data[63:32] !== e.d1) begin
          failures++;
          $display("FAIL %s rd_data1: got %h want %h", e.nm, bus.rd_data[63:32], e.d1);
        end
        checks++;
        if (bus.rd_busy !== e.b) begin
          failures++;
          $display("FAIL %s rd_busy: got %b want %b", e.nm, bus.rd_busy, e.b);
        end
      end
    end
  end

  task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic iv, input logic [4:0] ia, input logic fl);
    bus.rd_addr  = {r1, r0};
    bus.wr_en    = we;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.iss_vld  = iv;
    bus.iss_addr = ia;
    bus.flush    = fl;
  endtask

  // One clock cycle of stimulus with a checked expectation.
  task automatic cyc(input string nm, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic iv, input logic [4:0] ia, input logic fl,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    exp_t e;
    drive(r0, r1, we, wa0, wa1, wd0, wd1, iv, ia, fl);
    e.nm = nm; e.d0 = e0; e.d1 = e1; e.b = eb;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0;
  endtask

  // One clock cycle of stimulus without a check.
  task automatic idle(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic iv, input logic [4:0] ia);
    drive(5'd0, 5'd0, we, wa0, wa1, wd0, wd1, iv, ia, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_vld  = 1'b0;
    reset    = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    // Reset low: write and issue ignored, bypass suppressed.
    cyc("rst_byp", 5, 9, 2'b01, 5, 0, 32'hDEAD_BEEF, 0, 1'b1, 9, 1'b0, 0, 0, 2'b00);
    reset = 1'b1;

    for (int i = 0; i < 16; i++)
      cyc("t1_zero", 5'(2*i), 5'(2*i+1), 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 2'b00);

    cyc("t2_bypass", 5, 0, 2'b01, 5, 0, 32'h1234_5678, 0, 1'b0, 0, 1'b0, 32'h1234_5678, 0, 2'b00);
    cyc("t2_array",  5, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h1234_5678, 0, 2'b00);

    cyc("t3_coll", 7, 0, 2'b11, 7, 7, 32'hAAAA_0000, 32'hBBBB_0000, 1'b0, 0, 1'b0,
        32'hBBBB_0000, 0, 2'b00);
    cyc("t3_wr0", 7, 0, 2'b01, 0, 0, 32'hFFFF_FFFF, 0, 1'b0, 0, 1'b0, 32'hBBBB_0000, 0, 2'b00);
    cyc("t3_rd0", 0, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 32'hBBBB_0000, 2'b00);

    cyc("t4_iss",     9, 0, 2'b00, 0, 0, 0, 0, 1'b1, 9, 1'b0, 0, 0, 2'b00);
    cyc("t4_busy",    9, 9, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 2'b11);
    cyc("t4_wrclr",   9, 0, 2'b10, 0, 9, 0, 32'h99, 1'b0, 0, 1'b0, 32'h99, 0, 2'b00);
    cyc("t4_cleared", 9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h99, 0, 2'b00);
    cyc("t4_isswr",   9, 0, 2'b01, 9, 0, 32'h111, 0, 1'b1, 9, 1'b0, 32'h111, 0, 2'b00);
    cyc("t4_stays",   9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h111, 0, 2'b01);

    cyc("t5_iss3",  3, 4, 2'b00, 0, 0, 0, 0, 1'b1, 3, 1'b0, 0, 0, 2'b00);
    cyc("t5_iss4",  3, 4, 2'b00, 0, 0, 0, 0, 1'b1, 4, 1'b0, 0, 0, 2'b01);
    cyc("t5_iss6",  3, 4, 2'b00, 0, 0, 0, 0, 1'b1, 6, 1'b0, 0, 0, 2'b11);
    cyc("t5_flush", 6, 4, 2'b01, 4, 0, 32'h4444, 0, 1'b1, 10, 1'b1, 0, 32'h4444, 2'b01);
    cyc("t5_after", 6, 4, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 32'h4444, 2'b00);
    cyc("t5_noset", 10, 3, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 2'b00);

    // Fill 1..31 with A000_0000+addr; odd registers issued in the same cycle as their write.
    for (int j = 0; j < 15; j++)
      idle(2'b11, 5'(2*j+1), 5'(2*j+2), 32'hA000_0000 + 32'(2*j+1), 32'hA000_0000 + 32'(2*j+2),
           1'b1, 5'(2*j+1));
    idle(2'b01, 31, 0, 32'hA000_001F, 0, 1'b1, 31);
    cyc("t6_pre", 31, 2, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'hA000_001F, 32'hA000_0002, 2'b01);
    cyc("t6_odd", 17, 30, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'hA000_0011, 32'hA000_001E, 2'b01);
    reset = 1'b0;
    cyc("t6_rst",  31, 17, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    reset = 1'b1;
    cyc("t6_post", 31, 17, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    cyc("t6_wr",   1, 2, 2'b01, 1, 0, 32'h55, 0, 1'b0, 0, 1'b0, 32'h55, 0, 2'b00);
    cyc("t6_rd",   1, 2, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 32'h55, 0, 2'b00);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
